// File: rtl/ysyx_22040237_ifu_pkg.sv
// Shared definitions for the instruction fetch unit.
//   - IFU_XLEN / IFU_ILEN : PC/address width and instruction width
//   - IFU_RESET_PC        : first fetch address after reset
//   - ifu_state_e         : fetch FSM state encodings
//   - pc_misaligned()     : true when a PC is not 4-byte aligned
package ysyx_22040237_ifu_pkg;

  localparam int          IFU_XLEN     = 64;
  localparam int          IFU_ILEN     = 32;
  localparam logic [63:0] IFU_RESET_PC = 64'h0000_0000_8000_0000;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_OUT   = 2'd2,
    S_FAULT = 2'd3
  } ifu_state_e;

  // Instructions are 4-byte aligned; any set low bit is an alignment fault.
  function automatic logic pc_misaligned(input logic [1:0] pc_lsb);
    return (pc_lsb != 2'b00);
  endfunction

endpackage

// File: rtl/ysyx_22040237_ifu.sv
// Instruction fetch unit for the multi-cycle NPC.
// Owns the architectural PC, issues one instruction-memory read at a time,
// and hands each fetched word with its PC to decode.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   halt                block new fetch requests
//   redirect_valid/pc   jump target from the execute stage
//   imem_req_*          fetch request (valid/ready, address)
//   imem_rsp_*          fetch response (valid/ready, data, access error)
//   inst_valid/ready    instruction handshake toward decode (inst, inst_pc)
//   fetch_fault         sticky fault flag, fault_pc = offending PC
module ysyx_22040237_ifu
  import ysyx_22040237_ifu_pkg::*;
#(
  parameter int              XLEN     = IFU_XLEN,
  parameter int              ILEN     = IFU_ILEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(IFU_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            halt,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  output logic            imem_rsp_ready,
  input  logic [ILEN-1:0] imem_rsp_data,
  input  logic            imem_rsp_err,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [ILEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            fetch_fault,
  output logic [XLEN-1:0] fault_pc
);

  ifu_state_e      state_r;
  logic [XLEN-1:0] pc_r;
  logic [ILEN-1:0] inst_r;
  logic [XLEN-1:0] inst_pc_r;
  logic            fault_r;
  logic [XLEN-1:0] fault_pc_r;
  logic            drop_r;       // in-flight response belongs to a squashed PC

  logic            redir_bad_s;
  logic [XLEN-1:0] pc_inc_s;

  assign redir_bad_s   = redirect_valid && pc_misaligned(redirect_pc[1:0]);
  assign pc_inc_s      = pc_r + {{(XLEN-3){1'b0}}, 3'd4};
  assign imem_req_addr = pc_r;
  assign inst          = inst_r;
  assign inst_pc       = inst_pc_r;
  assign fetch_fault   = fault_r;
  assign fault_pc      = fault_pc_r;

  // Handshake strobes from the current state; all forced low during reset.
  always_comb begin
    imem_req_valid = 1'b0;
    imem_rsp_ready = 1'b0;
    inst_valid     = 1'b0;
    if (rst) begin
      case (state_r)
        S_REQ:   imem_req_valid = !halt && !redirect_valid;
        S_WAIT:  imem_rsp_ready = 1'b1;
        S_OUT:   inst_valid     = 1'b1;
        S_FAULT: imem_rsp_ready = 1'b1;  // drain a response left in flight
        default: imem_req_valid = 1'b0;
      endcase
    end else begin
      imem_req_valid = 1'b0;
    end
  end

  // Fetch FSM together with PC, instruction and fault registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= S_REQ;
      pc_r       <= RESET_PC;
      inst_r     <= {ILEN{1'b0}};
      inst_pc_r  <= {XLEN{1'b0}};
      fault_r    <= 1'b0;
      fault_pc_r <= {XLEN{1'b0}};
      drop_r     <= 1'b0;
    end else begin
      case (state_r)
        S_REQ: begin
          // req_valid is already masked by redirect, so the two never collide
          if (redir_bad_s) begin
            fault_r    <= 1'b1;
            fault_pc_r <= redirect_pc;
            state_r    <= S_FAULT;
          end else if (redirect_valid) begin
            pc_r <= redirect_pc;
          end else if (imem_req_valid && imem_req_ready) begin
            state_r <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (redir_bad_s) begin
            fault_r    <= 1'b1;
            fault_pc_r <= redirect_pc;
            state_r    <= S_FAULT;
          end else if (imem_rsp_valid) begin
            if (drop_r || redirect_valid) begin
              // stale word: throw it away and refetch from the new PC
              drop_r  <= 1'b0;
              state_r <= S_REQ;
              if (redirect_valid) begin
                pc_r <= redirect_pc;
              end
            end else if (imem_rsp_err) begin
              fault_r    <= 1'b1;
              fault_pc_r <= pc_r;
              state_r    <= S_FAULT;
            end else begin
              inst_r    <= imem_rsp_data;
              inst_pc_r <= pc_r;
              pc_r      <= pc_inc_s;
              state_r   <= S_OUT;
            end
          end else if (redirect_valid) begin
            pc_r   <= redirect_pc;
            drop_r <= 1'b1;
          end
        end
        S_OUT: begin
          // a redirect leaves S_OUT whether or not decode took the word
          if (redir_bad_s) begin
            fault_r    <= 1'b1;
            fault_pc_r <= redirect_pc;
            state_r    <= S_FAULT;
          end else if (redirect_valid) begin
            pc_r    <= redirect_pc;
            state_r <= S_REQ;
          end else if (inst_ready) begin
            state_r <= S_REQ;
          end
        end
        S_FAULT: begin
          state_r <= S_FAULT;
        end
        default: begin
          state_r <= S_FAULT;
        end
      endcase
    end
  end

endmodule
